muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit.
- Takes operands from the register file read ports (read_data1/read_data2) plus a destination register number.
- Computes the result over a fixed 32-cycle latency, then drives a one-cycle write-back (write_reg, write_data, regwrite) into the register file's write port.
- Valid/ready start handshake plus a kill input for pipeline flush.

---
 rtl/muldiv_unit_if.sv | 18 +
 rtl/muldiv_unit.sv | 84 ++++++++
 tb/tb_muldiv_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request and write-back bundle between the pipeline and muldiv_unit
interface muldiv_unit_if #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5
);
  logic start_valid, start_ready, kill, busy, regwrite;
  logic [2:0] funct3;
  logic [XLEN-1:0] operand_a, operand_b, write_data;
  logic [REG_ADDR_W-1:0] dest_reg, write_reg;
  modport master (
    output start_valid, funct3, operand_a, operand_b, dest_reg, kill,
    input  start_ready, busy, regwrite, write_reg, write_data
  );
  modport slave (
    input  start_valid, funct3, operand_a, operand_b, dest_reg, kill,
    output start_ready, busy, regwrite, write_reg, write_data
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, fixed 32-cycle latency, one-cycle write-back
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int REG_ADDR_W = 5
) (
  input logic clock,
  input logic reset_n,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;
  state_t state;
  logic [2:0] op;
  logic [REG_ADDR_W-1:0] rd, wr_q;
  logic [CW-1:0] cnt;
  logic sign_a, neg, div0, a_signed, b_signed, sa, sb, ge;
  logic [XLEN-1:0] opnd, abs_a, abs_b, rem_new, q, r, result, wd_q;
  logic [XLEN:0] add_sum, rem_sh;
  logic [2*XLEN-1:0] acc, acc_nxt, prod;
  // MUL treats both operands as signed: only the low half is kept, which is sign-agnostic
  assign a_signed = bus.funct3[2] ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
  assign b_signed = bus.funct3[2] ? ~bus.funct3[0] : ~bus.funct3[1];
  assign sa = a_signed & bus.operand_a[XLEN-1];
  assign sb = b_signed & bus.operand_b[XLEN-1];
  assign abs_a = sa ? -bus.operand_a : bus.operand_a;
  assign abs_b = sb ? -bus.operand_b : bus.operand_b;
  // multiply: acc = {partial sum, multiplier}; divide: acc = {remainder, dividend/quotient}
  assign add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign rem_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign ge = rem_sh >= {1'b0, opnd};
  assign rem_new = rem_sh[XLEN-1:0] - (ge ? opnd : '0);
  assign acc_nxt = op[2] ? {rem_new, acc[XLEN-2:0], ge} : {add_sum, acc[XLEN-1:1]};
  // divide-by-zero leaves |a| as remainder naturally; signed overflow wraps to 0x80000000 on its own
  assign prod = neg ? -acc_nxt : acc_nxt;
  assign q = acc_nxt[XLEN-1:0];
  assign r = acc_nxt[2*XLEN-1:XLEN];
  assign result = op[2] ? (op[1] ? (sign_a ? -r : r) : (div0 ? '1 : (neg ? -q : q)))
                        : (op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  assign bus.start_ready = state == IDLE;
  assign bus.busy = state != IDLE;
  assign bus.regwrite = state == WB && rd != '0 && !bus.kill;
  assign bus.write_reg = wr_q;
  assign bus.write_data = wd_q;
  // control FSM and datapath; a kill aborts without touching the write-back registers
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      op <= '0;
      rd <= '0;
      cnt <= '0;
      sign_a <= 1'b0;
      neg <= 1'b0;
      div0 <= 1'b0;
      opnd <= '0;
      acc <= '0;
      wr_q <= '0;
      wd_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start_valid && !bus.kill) begin
          state <= RUN;
          op <= bus.funct3;
          rd <= bus.dest_reg;
          cnt <= '0;
          sign_a <= sa;
          neg <= sa ^ sb;
          div0 <= bus.operand_b == '0;
          opnd <= bus.funct3[2] ? abs_b : abs_a;
          acc <= {{XLEN{1'b0}}, bus.funct3[2] ? abs_a : abs_b};
        end
        RUN: if (bus.kill) state <= IDLE;
          else begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(XLEN - 1)) begin
              state <= WB;
              wd_q <= result;
              wr_q <= rd;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: randomized self-checking bench for muldiv_unit against an arithmetic RV32M model
module tb_muldiv_unit;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int passed = 0;
  int total = 0;
  muldiv_unit_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();
  muldiv_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  always #5 clock = ~clock;

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    int ia = $signed(a);
    int ib = $signed(b);
    logic [63:0] p = f == 3'd3 ? ua * ub : f == 3'd2 ? sa * ub : sa * sb;
    if (f == 3'd0) return p[31:0];
    if (!f[2]) return p[63:32];
    if (b == 0) return f[1] ? a : 32'hFFFFFFFF;
    if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f[1] ? 32'h0 : 32'h80000000;
    case (f)
      3'd4: return ia / ib;
      3'd5: return a / b;
      3'd6: return ia % ib;
      default: return a % b;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return $urandom_range(0, 20);
      default: return $urandom;
    endcase
  endfunction

  // issue one request (accepted at edge N) and observe 40 following cycles
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                       input int pulse_at, input int kill_at, output int first, output int nhigh,
                       output int ready_at, output int busy_n, output logic [31:0] wd, output logic [4:0] wr);
    bus.funct3 = f; bus.operand_a = a; bus.operand_b = b; bus.dest_reg = rd;
    bus.start_valid = 1'b1; bus.kill = 1'b0;
    @(posedge clock); #1;
    bus.start_valid = 1'b0;
    bus.funct3 = 3'($urandom); bus.operand_a = $urandom; bus.operand_b = $urandom; bus.dest_reg = 5'($urandom);
    @(negedge clock);
    first = -1; nhigh = 0; ready_at = -1; busy_n = bus.busy ? 1 : 0; wd = 'x; wr = 'x;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock); #1;
      bus.start_valid = (i == pulse_at);
      bus.kill = (i == kill_at);
      @(negedge clock);
      if (bus.regwrite) begin
        if (first < 0) first = i;
        nhigh++; wd = bus.write_data; wr = bus.write_reg;
      end
      if (bus.busy) busy_n++;
      if (bus.start_ready && ready_at < 0) ready_at = i;
    end
    bus.start_valid = 1'b0; bus.kill = 1'b0;
  endtask

  task automatic test_reset();
    bus.start_valid = 1'b1; bus.kill = 1'b0; bus.funct3 = 3'd0;
    bus.operand_a = 32'd7; bus.operand_b = 32'd3; bus.dest_reg = 5'd1;
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    total++; if ({bus.busy, bus.regwrite, bus.start_ready} !== 3'b001) $display("FAIL reset_flags got busy/regwrite/ready=%b want 001", {bus.busy, bus.regwrite, bus.start_ready}); else passed++;
    total++; if (bus.write_data !== 32'h0 || bus.write_reg !== 5'h0) $display("FAIL reset_wb got data=%h reg=%0d want 0/0", bus.write_data, bus.write_reg); else passed++;
    bus.start_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clock);
    total++; if (bus.busy !== 1'b0 || bus.start_ready !== 1'b1) $display("FAIL reset_release got busy=%b ready=%b want 0/1", bus.busy, bus.start_ready); else passed++;
  endtask

  task automatic test_mul_basic();
    int first, nhigh, rdy, bn; logic [31:0] wd; logic [4:0] wr;
    do_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5, -1, -1, first, nhigh, rdy, bn, wd, wr);
    total++; if (first !== 32) $display("FAIL mul_latency got %0d want 32", first); else passed++;
    total++; if (nhigh !== 1) $display("FAIL mul_strobe_len got %0d want 1", nhigh); else passed++;
    total++; if (wr !== 5'd5) $display("FAIL mul_write_reg got %0d want 5", wr); else passed++;
    total++; if (wd !== 32'hFFFFFFEB) $display("FAIL mul_data got %h want ffffffeb", wd); else passed++;
    total++; if (rdy !== 33) $display("FAIL mul_ready_return got %0d want 33", rdy); else passed++;
  endtask

  task automatic test_mul_variants();
    logic [2:0] f_t[4] = '{3'd3, 3'd1, 3'd2, 3'd0};
    logic [31:0] e_t[4] = '{32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF, 32'h1};
    int first, nhigh, rdy, bn; logic [31:0] wd; logic [4:0] wr, rd;
    for (int k = 0; k < 4; k++) begin
      rd = 5'($urandom_range(1, 31));
      do_op(f_t[k], 32'hFFFFFFFF, 32'hFFFFFFFF, rd, -1, -1, first, nhigh, rdy, bn, wd, wr);
      total++; if (wd !== e_t[k] || wr !== rd || first !== 32) $display("FAIL mulvar_f%0d got data=%h reg=%0d at=%0d want %h/%0d/32", f_t[k], wd, wr, first, e_t[k], rd); else passed++;
    end
  endtask

  task automatic test_div();
    logic [2:0] f_t[4] = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] a_t[4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    logic [31:0] b_t[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] e_t[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    int first, nhigh, rdy, bn; logic [31:0] wd; logic [4:0] wr;
    for (int k = 0; k < 4; k++) begin
      do_op(f_t[k], a_t[k], b_t[k], 5'd7, -1, -1, first, nhigh, rdy, bn, wd, wr);
      total++; if (wd !== e_t[k] || first !== 32) $display("FAIL div_f%0d got data=%h at=%0d want %h/32", f_t[k], wd, first, e_t[k]); else passed++;
    end
  endtask

  task automatic test_special();
    logic [2:0] f_t[6] = '{3'd4, 3'd7, 3'd4, 3'd6, 3'd5, 3'd6};
    logic [31:0] a_t[6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd5, 32'hFFFFFFFB};
    logic [31:0] b_t[6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] e_t[6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFB};
    int first, nhigh, rdy, bn; logic [31:0] wd; logic [4:0] wr;
    for (int k = 0; k < 6; k++) begin
      do_op(f_t[k], a_t[k], b_t[k], 5'd9, -1, -1, first, nhigh, rdy, bn, wd, wr);
      total++; if (wd !== e_t[k] || first !== 32 || rdy !== 33) $display("FAIL special_%0d got data=%h at=%0d ready=%0d want %h/32/33", k, wd, first, rdy, e_t[k]); else passed++;
    end
  endtask

  task automatic test_random();
    int first, nhigh, rdy, bn; logic [31:0] wd, a, b, exp; logic [4:0] wr, rd; logic [2:0] f;
    for (int k = 0; k < 24; k++) begin
      f = 3'($urandom); a = pick(); b = pick(); rd = 5'($urandom_range(1, 31));
      exp = model(f, a, b);
      do_op(f, a, b, rd, -1, -1, first, nhigh, rdy, bn, wd, wr);
      total++; if (wd !== exp || wr !== rd || first !== 32 || nhigh !== 1) $display("FAIL random_f%0d a=%h b=%h got data=%h reg=%0d at=%0d n=%0d want %h/%0d/32/1", f, a, b, wd, wr, first, nhigh, exp, rd); else passed++;
    end
  endtask

  task automatic test_flow();
    int first, nhigh, rdy, bn; logic [31:0] wd; logic [4:0] wr;
    do_op(3'd0, 32'd6, 32'd7, 5'd0, -1, -1, first, nhigh, rdy, bn, wd, wr);
    total++; if (first !== -1) $display("FAIL rd0_strobe got first=%0d want none", first); else passed++;
    total++; if (bn !== 33 || rdy !== 33) $display("FAIL rd0_busy got busy=%0d ready=%0d want 33/33", bn, rdy); else passed++;
    total++; if (bus.write_data !== 32'd42) $display("FAIL rd0_data got %h want 0000002a", bus.write_data); else passed++;
    do_op(3'd5, 32'd100, 32'd7, 5'd12, 5, -1, first, nhigh, rdy, bn, wd, wr);
    total++; if (nhigh !== 1 || first !== 32 || wd !== 32'd14 || wr !== 5'd12 || rdy !== 33) $display("FAIL busy_ignore got n=%0d at=%0d data=%h reg=%0d ready=%0d want 1/32/e/12/33", nhigh, first, wd, wr, rdy); else passed++;
    do_op(3'd0, 32'd9, 32'd9, 5'd13, -1, 10, first, nhigh, rdy, bn, wd, wr);
    total++; if (first !== -1 || rdy !== 11) $display("FAIL kill_run got first=%0d ready=%0d want none/11", first, rdy); else passed++;
    total++; if (bus.write_data !== 32'd14 || bus.write_reg !== 5'd12) $display("FAIL kill_hold got data=%h reg=%0d want e/12", bus.write_data, bus.write_reg); else passed++;
    do_op(3'd0, 32'd2, 32'd3, 5'd14, -1, 32, first, nhigh, rdy, bn, wd, wr);
    total++; if (first !== -1 || rdy !== 33) $display("FAIL kill_wb got first=%0d ready=%0d want none/33", first, rdy); else passed++;
    bus.start_valid = 1'b1; bus.kill = 1'b1;
    @(posedge clock); #1;
    bus.start_valid = 1'b0; bus.kill = 1'b0;
    @(negedge clock);
    total++; if (bus.busy !== 1'b0 || bus.start_ready !== 1'b1) $display("FAIL kill_idle got busy=%b ready=%b want 0/1", bus.busy, bus.start_ready); else passed++;
  endtask

  task automatic test_async_reset();
    int first, nhigh, rdy, bn, seen; logic [31:0] wd; logic [4:0] wr;
    do_op(3'd0, 32'd3, 32'd5, 5'd9, -1, -1, first, nhigh, rdy, bn, wd, wr);
    total++; if (wd !== 32'd15) $display("FAIL prereset_data got %h want 0000000f", wd); else passed++;
    bus.funct3 = 3'd0; bus.operand_a = 32'd11; bus.operand_b = 32'd13; bus.dest_reg = 5'd3; bus.start_valid = 1'b1;
    @(posedge clock); #1;
    bus.start_valid = 1'b0;
    repeat (20) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.regwrite !== 1'b0 || bus.start_ready !== 1'b1) $display("FAIL async_reset_flags got busy=%b rw=%b ready=%b want 0/0/1", bus.busy, bus.regwrite, bus.start_ready); else passed++;
    total++; if (bus.write_data !== 32'h0 || bus.write_reg !== 5'h0) $display("FAIL async_reset_wb got data=%h reg=%0d want 0/0", bus.write_data, bus.write_reg); else passed++;
    @(negedge clock);
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.regwrite || bus.busy) seen++;
    end
    total++; if (seen !== 0) $display("FAIL async_reset_discard got %0d active cycles want 0", seen); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [4:0] rd_q[$];
    int due_q[$];
    int issued = 0, last = 0, seen = 0;
    logic acc_now;
    bus.funct3 = 3'($urandom); bus.operand_a = pick(); bus.operand_b = pick();
    bus.dest_reg = 5'($urandom_range(1, 31)); bus.start_valid = 1'b1; bus.kill = 1'b0;
    for (int c = 1; c <= 6 * 34 + 40; c++) begin
      acc_now = bus.start_valid && bus.start_ready;
      @(posedge clock); #1;
      if (acc_now) begin
        exp_q.push_back(model(bus.funct3, bus.operand_a, bus.operand_b));
        rd_q.push_back(bus.dest_reg);
        due_q.push_back(c + 32);
        if (issued > 0) begin
          total++; if (c - last !== 34) $display("FAIL b2b_spacing got %0d want 34", c - last); else passed++;
        end
        last = c; issued++;
        if (issued < 6) begin
          bus.funct3 = 3'($urandom); bus.operand_a = pick(); bus.operand_b = pick();
          bus.dest_reg = 5'($urandom_range(1, 31));
        end else bus.start_valid = 1'b0;
      end
      @(negedge clock);
      if (bus.regwrite) begin
        total++;
        if (due_q.size() == 0) $display("FAIL b2b_spurious got regwrite at %0d want none", c);
        else begin
          if (c !== due_q[0] || bus.write_data !== exp_q[0] || bus.write_reg !== rd_q[0]) $display("FAIL b2b_result got at=%0d data=%h reg=%0d want %0d/%h/%0d", c, bus.write_data, bus.write_reg, due_q[0], exp_q[0], rd_q[0]); else passed++;
          void'(due_q.pop_front()); void'(exp_q.pop_front()); void'(rd_q.pop_front());
          seen++;
        end
      end else if (due_q.size() > 0 && due_q[0] == c) begin
        total++; $display("FAIL b2b_missing got no regwrite at %0d want %h", c, exp_q[0]);
        void'(due_q.pop_front()); void'(exp_q.pop_front()); void'(rd_q.pop_front());
      end
    end
    total++; if (seen !== 6) $display("FAIL b2b_count got %0d want 6", seen); else passed++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_variants();
    test_div();
    test_special();
    test_random();
    test_flow();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
